// File: rtl/port_dec_pkg.sv
// Shared constants and helpers for the registered port strobe decoder.
package port_dec_pkg;

    // Default select and counter widths.
    localparam int unsigned DefSelW = 3;
    localparam int unsigned DefCntW = 16;

    // Widest select the one-hot helper supports.
    localparam int unsigned MaxSelW  = 8;
    localparam int unsigned MaxPorts = 256;

    // Number of decoded ports for a given select width.
    function automatic int unsigned num_ports(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

    // One-hot decode at maximum width; callers truncate to their port count.
    function automatic logic [MaxPorts-1:0] onehot(input logic [MaxSelW-1:0] sel);
        logic [MaxPorts-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/strobe_edge.sv
// Single-bit registered rising-edge detector. The history register resets
// to 0, so an input already high at reset release reads as a rising edge.
module strobe_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic rise
);

    logic in_q;

    // Track the previous input value every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/port_strobe_dec.sv
// Registered one-hot port read/write strobe decoder with rising-edge
// qualification, sticky collision flag and last-select capture.
// Optional macro ACCESS_CNT_EN adds saturating read/write access counters;
// without it rd_cnt and wr_cnt are tied to 0.
module port_strobe_dec
    import port_dec_pkg::*;
#(
    parameter  int unsigned SEL_W     = DefSelW,
    parameter  int unsigned CNT_W     = DefCntW,
    localparam int unsigned NUM_PORTS = 2 ** SEL_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en_n,
    input  logic                 r_strobe,
    input  logic                 w_strobe,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 coll_clr,
    output logic [NUM_PORTS-1:0] read,
    output logic [NUM_PORTS-1:0] write,
    output logic                 collision,
    output logic [SEL_W-1:0]     last_sel,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [CNT_W-1:0]     wr_cnt
);

    logic r_rise;
    logic w_rise;
    logic rd_go;
    logic wr_go;
    logic coll_set;

    logic [NUM_PORTS-1:0] decoded;
    logic [NUM_PORTS-1:0] read_d,  read_q;
    logic [NUM_PORTS-1:0] write_d, write_q;
    logic                 collision_d, collision_q;
    logic [SEL_W-1:0]     last_sel_d, last_sel_q;

    strobe_edge u_r_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (r_strobe),
        .rise    (r_rise)
    );

    strobe_edge u_w_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (w_strobe),
        .rise    (w_rise)
    );

    // Qualify edges; simultaneous read/write edges flag a collision instead of a pulse.
    always_comb begin
        rd_go    = ~en_n & r_rise & ~w_rise;
        wr_go    = ~en_n & w_rise & ~r_rise;
        coll_set = ~en_n & r_rise & w_rise;
        decoded  = NUM_PORTS'(onehot(MaxSelW'(sel)));

        read_d      = rd_go ? decoded : '0;
        write_d     = wr_go ? decoded : '0;
        last_sel_d  = (rd_go | wr_go) ? sel : last_sel_q;
        collision_d = collision_q;
        if (coll_set) begin
            collision_d = 1'b1;
        end else if (coll_clr) begin
            collision_d = 1'b0;
        end
    end

    // Output pulse, collision and select capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_q      <= '0;
            write_q     <= '0;
            collision_q <= 1'b0;
            last_sel_q  <= '0;
        end else begin
            read_q      <= read_d;
            write_q     <= write_d;
            collision_q <= collision_d;
            last_sel_q  <= last_sel_d;
        end
    end

    assign read      = read_q;
    assign write     = write_q;
    assign collision = collision_q;
    assign last_sel  = last_sel_q;

`ifdef ACCESS_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] wr_cnt_q;

    // Saturating access counters, updated on the same edge as the pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_go && (rd_cnt_q != CntMax)) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (wr_go && (wr_cnt_q != CntMax)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule
